// File: rtl/uart_tx_core.sv
// UART transmit engine: pops 10-bit words from the TX FIFO and serialises them
// as start / 7-10 data bits LSB-first / optional parity / 1-2 stop / idle gap.
module uart_tx_core (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] r_clkdiv,
  input  logic [3:0]  r_oversampling,
  input  logic [1:0]  r_data_bit,
  input  logic        r_parity_en,
  input  logic [1:0]  r_parity,
  input  logic        r_stop_bit,
  input  logic [3:0]  r_interval_bit,
  input  logic        r_cts,
  input  logic        r_tx_logic_clr,
  input  logic        cts_n,
  input  logic        tx_fifo_empty,
  input  logic [9:0]  tx_fifo_rdata,
  output logic        tx_fifo_rd,
  output logic        txd,
  output logic        tx_busy,
  output logic        tx_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP
  } state_e;

  state_e      state_q;
  logic [11:0] pre_q, clkdiv_q;
  logic [3:0]  tick_q, ovs_q, bit_q, nb_q, iv_q;
  logic [9:0]  word_q;
  logic [1:0]  par_q;
  logic        par_en_q, stop2_q;
  logic        txd_q, rd_q, busy_q, done_q;
  logic        cts_s1_q, cts_s2_q;

  logic        bit_end, data_last, stop_last, gap_last, cts_ok, idle_next, pop;

  function automatic logic [9:0] data_mask(input logic [1:0] db);
    case (db)
      2'd0:    data_mask = 10'h07F;
      2'd1:    data_mask = 10'h0FF;
      2'd2:    data_mask = 10'h1FF;
      default: data_mask = 10'h3FF;
    endcase
  endfunction

  // word_q is stored already masked, so even parity is a plain reduction
  function automatic logic par_bit(input logic [9:0] w, input logic [1:0] mode);
    case (mode)
      2'd0:    par_bit = ^w;
      2'd1:    par_bit = ~^w;
      2'd2:    par_bit = 1'b1;
      default: par_bit = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cts_s1_q <= 1'b1;
      cts_s2_q <= 1'b1;
    end else begin
      cts_s1_q <= cts_n;
      cts_s2_q <= cts_s1_q;
    end
  end

  // idle_next covers both steady IDLE and the edge that returns to IDLE, so a
  // queued word pops without an extra idle clock between frames
  always_comb begin
    bit_end   = (pre_q == clkdiv_q) && (tick_q == ovs_q);
    data_last = (bit_q == nb_q - 4'd1);
    stop_last = !stop2_q || bit_q[0];
    gap_last  = (bit_q == iv_q - 4'd1);
    cts_ok    = !r_cts || !cts_s2_q;
    idle_next = ((state_q == S_IDLE) && !rd_q) ||
                ((state_q == S_STOP) && bit_end && stop_last && (iv_q == 4'd0)) ||
                ((state_q == S_GAP) && bit_end && gap_last);
    pop       = idle_next && !tx_fifo_empty && cts_ok;
  end

  always_ff @(posedge clk) begin
    if (rst || r_tx_logic_clr) begin
      state_q  <= S_IDLE;
      pre_q    <= '0;
      tick_q   <= '0;
      bit_q    <= '0;
      word_q   <= '0;
      txd_q    <= 1'b1;
      rd_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      if (rst) begin
        clkdiv_q <= '0;
        ovs_q    <= '0;
        nb_q     <= '0;
        iv_q     <= '0;
        par_q    <= '0;
        par_en_q <= 1'b0;
        stop2_q  <= 1'b0;
      end
    end else begin
      rd_q   <= 1'b0;
      done_q <= 1'b0;

      if (state_q == S_IDLE) begin
        pre_q  <= '0;
        tick_q <= '0;
      end else if (pre_q == clkdiv_q) begin
        pre_q  <= '0;
        tick_q <= (tick_q == ovs_q) ? 4'd0 : tick_q + 4'd1;
      end else begin
        pre_q <= pre_q + 12'd1;
      end

      case (state_q)
        S_IDLE: begin
          txd_q <= 1'b1;
          if (rd_q) begin
            state_q <= S_START;
            txd_q   <= 1'b0;
            bit_q   <= '0;
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_START: if (bit_end) begin
          state_q <= S_DATA;
          bit_q   <= '0;
          txd_q   <= word_q[0];
        end
        S_DATA: if (bit_end) begin
          if (data_last) begin
            bit_q <= '0;
            if (par_en_q) begin
              state_q <= S_PARITY;
              txd_q   <= par_bit(word_q, par_q);
            end else begin
              state_q <= S_STOP;
              txd_q   <= 1'b1;
            end
          end else begin
            bit_q <= bit_q + 4'd1;
            txd_q <= word_q[bit_q + 4'd1];
          end
        end
        S_PARITY: if (bit_end) begin
          state_q <= S_STOP;
          bit_q   <= '0;
          txd_q   <= 1'b1;
        end
        S_STOP: begin
          txd_q <= 1'b1;
          if (bit_end) begin
            if (!stop_last) begin
              bit_q <= 4'd1;
            end else begin
              done_q <= 1'b1;
              bit_q  <= '0;
              if (iv_q != 4'd0) begin
                state_q <= S_GAP;
              end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
        end
        S_GAP: begin
          txd_q <= 1'b1;
          if (bit_end) begin
            if (gap_last) begin
              state_q <= S_IDLE;
              bit_q   <= '0;
              busy_q  <= 1'b0;
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          txd_q   <= 1'b1;
        end
      endcase

      // frame format is captured here; later register writes don't touch it
      if (pop) begin
        rd_q     <= 1'b1;
        busy_q   <= 1'b1;
        word_q   <= tx_fifo_rdata & data_mask(r_data_bit);
        nb_q     <= 4'd7 + {2'b00, r_data_bit};
        par_en_q <= r_parity_en;
        par_q    <= r_parity;
        stop2_q  <= r_stop_bit;
        iv_q     <= r_interval_bit;
        clkdiv_q <= r_clkdiv;
        ovs_q    <= r_oversampling;
      end
    end
  end

  assign tx_fifo_rd = rd_q;
  assign txd        = txd_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;

endmodule
